uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 serial line into a CSR-readable byte queue with sticky error flags.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables the parity_err flag.
module uart_rx #(
  parameter int unsigned ClksPerBit = 868,
  parameter int unsigned QueueDepth = 32,
  parameter logic [11:0] Addr       = 12'h052
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_i,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_data_out,
  output logic        have_next
);

  localparam int unsigned IdxW      = $clog2(QueueDepth);
  localparam int unsigned PtrW      = IdxW + 1;
  localparam logic [15:0] BitTicks  = 16'(ClksPerBit);
  localparam logic [15:0] HalfTicks = 16'(ClksPerBit / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // Line synchronizer
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive state machine
  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_timer;
  logic [15:0] w_timer_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        w_tick;
  logic        w_push_req;
  logic        w_frame_set;
`ifdef UART_RX_PARITY_EN
  logic        w_parity_set;
`endif

  // The timer expires on the cycle it holds 1, so a load of N spaces samples N cycles apart.
  assign w_tick = (r_timer <= 16'd1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= StIdle;
      r_timer   <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_push_req     = 1'b0;
    w_frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_set   = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        if (!r_rx_sync) begin
          w_state_next   = StStart;
          w_timer_next   = HalfTicks;
          w_bit_idx_next = 3'd0;
        end
      end
      StStart: begin
        if (!w_tick) begin
          w_timer_next = r_timer - 16'd1;
        end else if (!r_rx_sync) begin
          w_state_next = StData;
          w_timer_next = BitTicks;
        end else begin
          // Line back high at mid start bit: treat as a glitch
          w_state_next = StIdle;
          w_timer_next = 16'd0;
        end
      end
      StData: begin
        if (!w_tick) begin
          w_timer_next = r_timer - 16'd1;
        end else begin
          w_shift_next = {r_rx_sync, r_shift[7:1]};
          w_timer_next = BitTicks;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = 3'd0;
`ifdef UART_RX_PARITY_EN
            w_state_next   = StParity;
`else
            w_state_next   = StStop;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!w_tick) begin
          w_timer_next = r_timer - 16'd1;
        end else begin
          w_parity_set = (r_rx_sync != (^r_shift));
          w_state_next = StStop;
          w_timer_next = BitTicks;
        end
      end
`endif
      StStop: begin
        if (!w_tick) begin
          w_timer_next = r_timer - 16'd1;
        end else begin
          w_push_req   = r_rx_sync;
          w_frame_set  = !r_rx_sync;
          w_state_next = StIdle;
          w_timer_next = 16'd0;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_timer_next = 16'd0;
      end
    endcase
  end

  // Receive queue; pointers carry one extra wrap bit to tell full from empty
  logic [7:0]      r_mem [QueueDepth];
  logic [PtrW-1:0] r_in_ptr;
  logic [PtrW-1:0] r_out_ptr;
  logic            r_have_next;
  logic            w_empty;
  logic            w_full;
  logic            w_csr_hit;
  logic            w_pop;
  logic            w_push;
  logic            w_overrun_set;

  assign w_empty = (r_in_ptr == r_out_ptr);
  assign w_full  = (r_in_ptr[IdxW-1:0] == r_out_ptr[IdxW-1:0]) &&
                   (r_in_ptr[IdxW] != r_out_ptr[IdxW]);
  assign w_csr_hit     = csr_enable && (csr_addr == Addr);
  assign w_pop         = w_csr_hit && !w_empty;
  // A simultaneous pop frees the slot, so a push to a full queue still lands
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_overrun_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_in_ptr[IdxW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_in_ptr    <= '0;
      r_out_ptr   <= '0;
      r_have_next <= 1'b0;
    end else begin
      if (w_push) begin
        r_in_ptr <= r_in_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_out_ptr <= r_out_ptr + PtrW'(1);
      end
      r_have_next <= !w_empty;
    end
  end

  // Sticky flags: a clearing read loses to a same-cycle set
  logic r_frame_err;
  logic r_overrun;
  logic w_parity_err;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= (r_frame_err && !w_csr_hit) || w_frame_set;
      r_overrun   <= (r_overrun && !w_csr_hit) || w_overrun_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (r_parity_err && !w_csr_hit) || w_parity_set;
    end
  end

  assign w_parity_err = r_parity_err;
`else
  assign w_parity_err = 1'b0;
`endif

  always_comb begin
    csr_data_out       = 32'd0;
    csr_data_out[7:0]  = w_empty ? 8'h00 : r_mem[r_out_ptr[IdxW-1:0]];
    csr_data_out[8]    = r_have_next;
    csr_data_out[9]    = r_frame_err;
    csr_data_out[10]   = r_overrun;
    csr_data_out[11]   = w_parity_err;
  end

  assign have_next = r_have_next;

endmodule
